// File: rtl/bcd_to_7segment.sv
// Registered BCD-to-seven-segment decoder for one display digit.
// Segment order is {a,b,c,d,e,f,g}; ACTIVE_LOW inverts the segments only, never err.
module bcd_to_7segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic err
);

    // XOR mask that turns an active-high segment pattern into the pad polarity.
    localparam logic [6:0] POL_MASK = {7{ACTIVE_LOW}};

    logic [3:0] bcd;
    logic [6:0] seg_raw;
    logic [6:0] seg_d, seg_q;
    logic       err_d, err_q;

    assign bcd = {A, B, C, D};

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can be inferred.
        seg_raw = 7'b0000000;
        err_d   = 1'b0;
        case (bcd)
            4'd0:    seg_raw = 7'b1111110;
            4'd1:    seg_raw = 7'b0110000;
            4'd2:    seg_raw = 7'b1101101;
            4'd3:    seg_raw = 7'b1111001;
            4'd4:    seg_raw = 7'b0110011;
            4'd5:    seg_raw = 7'b1011011;
            4'd6:    seg_raw = 7'b1011111;
            4'd7:    seg_raw = 7'b1110000;
            4'd8:    seg_raw = 7'b1111111;
            4'd9:    seg_raw = 7'b1111011;
            default: err_d   = 1'b1;
        endcase
        seg_d = seg_raw ^ POL_MASK;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            seg_q <= POL_MASK;
            err_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            err_q <= err_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_to_7segment.sv
// Self-checking bench: both polarities driven from one input stream, checked via a scoreboard queue.
module tb_bcd_to_7segment;

    typedef struct packed {
        logic [6:0] seg_hi;
        logic       err_hi;
        logic [6:0] seg_lo;
        logic       err_lo;
        logic [3:0] code;
        logic       rst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic [6:0] seg0, seg1;
    logic       err0, err1;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_to_7segment #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
        .a(seg0[6]), .b(seg0[5]), .c(seg0[4]), .d(seg0[3]),
        .e(seg0[2]), .f(seg0[1]), .g(seg0[0]), .err(err0)
    );

    bcd_to_7segment #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
        .a(seg1[6]), .b(seg1[5]), .c(seg1[4]), .d(seg1[3]),
        .e(seg1[2]), .f(seg1[1]), .g(seg1[0]), .err(err1)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got seg/err=%b_%b want %b_%b at %0t",
                     tag, got[7:1], got[0], want[7:1], want[0], $time);
        end
    endtask

    // Drive one code (optionally with reset), push the expectation, clock it, then pop and compare.
    task automatic step(input logic r, input logic [3:0] code);
        exp_t ex;
        exp_t obs;
        rst = r;
        {A, B, C, D} = code;
        ex.code = code;
        ex.rst  = r;
        if (r) begin
            ex.seg_hi = 7'b0000000;
            ex.err_hi = 1'b0;
            ex.seg_lo = 7'b1111111;
            ex.err_lo = 1'b0;
        end else begin
            ex.seg_hi = ref_seg(code);
            ex.err_hi = (code > 4'd9);
            ex.seg_lo = ~ref_seg(code);
            ex.err_lo = (code > 4'd9);
        end
        sb.push_back(ex);
        @(posedge clk);
        #1;
        obs = sb.pop_front();
        check($sformatf("hi r=%b code=%b", obs.rst, obs.code), {seg0, err0}, {obs.seg_hi, obs.err_hi});
        check($sformatf("lo r=%b code=%b", obs.rst, obs.code), {seg1, err1}, {obs.seg_lo, obs.err_lo});
    endtask

    initial begin
        // Reset held for two edges with a valid code pending, then released.
        step(1'b1, 4'b1000);
        step(1'b1, 4'b1000);
        step(1'b0, 4'b1000);

        for (int i = 0; i <= 9; i++) step(1'b0, 4'(i));
        for (int i = 10; i <= 15; i++) step(1'b0, 4'(i));
        step(1'b0, 4'b0001);

        // Reset mid-stream while 0101 is presented.
        step(1'b0, 4'b0011);
        step(1'b0, 4'b0100);
        step(1'b1, 4'b0101);
        step(1'b0, 4'b0101);

        step(1'b0, 4'b1100);
        step(1'b0, 4'b0000);

        for (int i = 0; i < 8; i++) step(1'b0, (i % 2 == 0) ? 4'b1001 : 4'b1111);

        for (int i = 0; i < 20; i++) step(1'b0, 4'($urandom_range(0, 15)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
